tt_sweep_driver: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 7 +
 rtl/tt_sweep_if.sv | 9 +
 rtl/tt_misr.sv | 34 +++
 rtl/tt_sweep_driver.sv | 101 ++++++++++
 tb/tb_tt_sweep_driver.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep driver.
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;
endpackage

// File: rtl/tt_sweep_if.sv
// Row stream from the sweep driver: valid/ready handshake carrying {x, f}.
interface tt_sweep_if #(parameter int ROW_W = 13);
  logic             tt_valid;
  logic             tt_ready;
  logic [ROW_W-1:0] tt_row;

  modport master (output tt_valid, output tt_row, input tt_ready);
  modport slave  (input tt_valid, input tt_row, output tt_ready);
endinterface

// File: rtl/tt_misr.sv
// Multiple-input signature register over sampled netlist outputs.
// Seed load and one shift per accepted row, both on the next clock edge.
module tt_misr
  import tt_sweep_pkg::*;
#(
  parameter int SIG_W = 32,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             shift_en,
  input  logic [N_OUT-1:0] din,
  output logic [SIG_W-1:0] sig
);
  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);
  localparam logic [SIG_W-1:0] SEED = SIG_W'(MISR_SEED);

  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load_seed) begin
      sig <= SEED;
    end else if (shift_en) begin
      sig <= sig_next;
    end
  end
endmodule

// File: rtl/tt_sweep_driver.sv
// Walks every input vector into a combinational netlist, samples its outputs and streams each row.
// Row cost SETTLE+2 cycles; a stalled row holds x_out, tt_row and the signature until accepted.
module tt_sweep_driver
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 10,
  parameter int SETTLE = 0,
  parameter int SIG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  x_out,
  input  logic [N_OUT-1:0] f_in,
  tt_sweep_if.master       tt,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);
  localparam logic [N_IN-1:0] X_LAST   = '1;
  localparam logic [7:0]      SETTLE_V = 8'(SETTLE);

  state_t                  state_q, state_d;
  logic [7:0]              settle_cnt;
  logic [N_IN+N_OUT-1:0]   row_q;
  logic                    load_seed, shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_seed = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_seed = 1'b1;
          state_d   = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt == 8'd0) state_d = EMIT;
      end
      EMIT: begin
        if (tt.tt_ready) begin
          shift_en = 1'b1;
          state_d  = (x_out == X_LAST) ? DONE : APPLY;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last vector is kept on x_out after the sweep; termination is by compare, never by wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out      <= '0;
      settle_cnt <= '0;
      row_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_out      <= '0;
            settle_cnt <= SETTLE_V;
          end
        end
        APPLY: begin
          if (settle_cnt == 8'd0) row_q      <= {x_out, f_in};
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        EMIT: begin
          if (tt.tt_ready && (x_out != X_LAST)) begin
            x_out      <= x_out + 1'b1;
            settle_cnt <= SETTLE_V;
          end
        end
        default: ;
      endcase
    end
  end

  assign tt.tt_valid = (state_q == EMIT);
  assign tt.tt_row   = row_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  tt_misr #(.SIG_W(SIG_W), .N_OUT(N_OUT)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_seed(load_seed),
    .shift_en (shift_en),
    .din      (f_in),
    .sig      (signature)
  );
endmodule

// File: tb/tb_tt_sweep_driver.sv
// Drives two driver instances (SETTLE=0 and SETTLE=2) with table-defined netlists and random backpressure.
module tb_tt_sweep_driver;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int   sel;
  logic start_v, ready_v;
  logic [9:0] lut [8];

  logic [2:0]  x_a, x_b;
  logic [9:0]  f_a, f_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] sig_a, sig_b;

  tt_sweep_if #(.ROW_W(13)) if_a ();
  tt_sweep_if #(.ROW_W(13)) if_b ();

  assign f_a = lut[x_a];
  assign f_b = lut[x_b];
  assign if_a.tt_ready = (sel == 0) && ready_v;
  assign if_b.tt_ready = (sel == 1) && ready_v;

  tt_sweep_driver #(.N_IN(3), .N_OUT(10), .SETTLE(0), .SIG_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start((sel == 0) && start_v), .x_out(x_a), .f_in(f_a),
    .tt(if_a), .busy(busy_a), .done(done_a), .signature(sig_a));

  tt_sweep_driver #(.N_IN(3), .N_OUT(10), .SETTLE(2), .SIG_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start((sel == 1) && start_v), .x_out(x_b), .f_in(f_b),
    .tt(if_b), .busy(busy_b), .done(done_b), .signature(sig_b));

  logic        m_valid, m_busy, m_done;
  logic [12:0] m_row;
  logic [2:0]  m_x;
  logic [31:0] m_sig;
  assign m_valid = (sel == 0) ? if_a.tt_valid : if_b.tt_valid;
  assign m_row   = (sel == 0) ? if_a.tt_row   : if_b.tt_row;
  assign m_x     = (sel == 0) ? x_a    : x_b;
  assign m_busy  = (sel == 0) ? busy_a : busy_b;
  assign m_done  = (sel == 0) ? done_a : done_b;
  assign m_sig   = (sel == 0) ? sig_a  : sig_b;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Signature of one full sweep: seed of all ones, shifted once per row by the CRC-32 polynomial.
  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int x = 0; x < 8; x++) begin
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {22'h0, lut[x]};
    end
    return s;
  endfunction

  task automatic fill_lut(input int kind);
    for (int x = 0; x < 8; x++) begin
      if (kind == 0)      lut[x] = 10'(x);
      else if (kind == 1) lut[x] = 10'h0;
      else                lut[x] = 10'($urandom_range(0, 1023));
    end
  endtask

  // mode 0: ready high; 1: ready low 5 cycles at row 3; 2: random ready; 3: re-start at row 4
  task automatic run_sweep(input int s, input int mode);
    int          settle, k, stalls, stall_left, first_valid, last_hs, done_at, done_cnt;
    bit          stalled, restarted, rdy;
    logic [31:0] exp_sig;
    sel = s;
    settle = (s == 0) ? 0 : 2;
    exp_sig = model_sig();
    k = 0; stalls = 0; stall_left = 5; first_valid = -1; last_hs = -1;
    done_at = -1; done_cnt = 0; stalled = 0; restarted = 0;
    @(posedge clk); #1;
    start_v = 1'b1;
    ready_v = 1'b1;
    for (int i = 1; i < 400; i++) begin
      @(posedge clk); #1;
      start_v = 1'b0;
      if (mode == 3 && m_valid && k == 4 && !restarted) begin
        start_v   = 1'b1;
        restarted = 1'b1;
      end
      rdy = 1'b1;
      if (mode == 1 && m_valid && k == 3 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      ready_v = rdy;
      if (m_valid) begin
        if (first_valid < 0) begin
          first_valid = i;
          chk("first_valid", 64'(i), 64'(settle + 2));
        end
        if (k > 7) begin
          chk("extra_row", 64'(k), 64'd7);
        end else begin
          chk("x_out", 64'(m_x), 64'(k));
          chk("row", 64'(m_row), 64'({k[2:0], lut[k]}));
        end
        if (rdy) begin
          if (last_hs >= 0 && !stalled) chk("row_spacing", 64'(i - last_hs), 64'(settle + 2));
          last_hs = i;
          stalled = 1'b0;
          k++;
        end else begin
          stalls++;
          stalled = 1'b1;
        end
      end
      if (m_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = i;
          chk("done_time", 64'(i), 64'(8 * (settle + 2) + 1 + stalls));
          chk("row_count", 64'(k), 64'd8);
          chk("signature", 64'(m_sig), 64'(exp_sig));
        end
      end
      chk("busy", 64'(m_busy), 64'((done_at < 0 || i == done_at) ? 1 : 0));
      if (done_at >= 0 && i >= done_at + 4) break;
    end
    ready_v = 1'b0;
    start_v = 1'b0;
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("sig_hold", 64'(m_sig), 64'(exp_sig));
    chk("x_hold", 64'(m_x), 64'd7);
  endtask

  task automatic run_abort();
    bit hit;
    sel = 0;
    hit = 1'b0;
    @(posedge clk); #1;
    start_v = 1'b1;
    ready_v = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start_v = 1'b0;
      if (m_valid && m_x == 3'd5) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reach_row5", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_row",   64'(m_row),   64'd0);
    chk("abort_x",     64'(m_x),     64'd0);
    chk("abort_busy",  64'(m_busy),  64'd0);
    chk("abort_sig",   64'(m_sig),   64'd0);
    ready_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_abort_busy", 64'(m_busy), 64'd0);
      chk("post_abort_done", 64'(m_done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start_v = 1'b0;
    ready_v = 1'b0;
    sel     = 0;
    fill_lut(1);
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_row",   64'(m_row),   64'd0);
      chk("rst_x",     64'(m_x),     64'd0);
      chk("rst_busy",  64'(m_busy),  64'd0);
      chk("rst_done",  64'(m_done),  64'd0);
      chk("rst_sig",   64'(m_sig),   64'd0);
    end
    sel = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    fill_lut(0); run_sweep(0, 0);
    fill_lut(0); run_sweep(0, 1);
    fill_lut(0); run_sweep(1, 0);
    fill_lut(2); run_sweep(0, 3);
    fill_lut(2); run_abort();
    run_sweep(0, 0);
    fill_lut(1); run_sweep(0, 0);
    for (int r = 0; r < 4; r++) begin
      fill_lut(2);
      run_sweep(r % 2, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
